// File: rtl/tube_scan_driver.sv
// Scan-index generator and frame-synchronous display register feeding the 4-digit tube controller.
// Latency: an accepted request shows on the outputs at the next frame boundary (dig 3->0), or at the one after if accepted in that same cycle.
// Backpressure: one-entry pending slot; loadReady is low from the cycle after an accept until the commit cycle.
module tube_scan_driver #(
    parameter int PRESCALE  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        loadValid,
    output logic        loadReady,
    input  logic [15:0] loadValue,
    input  logic [1:0]  loadMode,
    input  logic [3:0]  loadLabel,
    input  logic [3:0]  loadDots,
    input  logic        loadBlink,
    output logic [1:0]  dig,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4,
    output logic [3:0]  dots,
    output logic [3:0]  auxs
);

    // Counter widths; a divide-by-one still needs a one-bit register.
    localparam int PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    // Display modes
    localparam logic [1:0] MODE_HEX   = 2'd0;
    localparam logic [1:0] MODE_LABEL = 2'd1;
    localparam logic [1:0] MODE_BLANK = 2'd2;

    // Prescaler and scan state
    logic [PW-1:0] pre;
    logic          tick;
    logic          frame_end;

    // Pending request slot
    logic          pend_full;
    logic [15:0]   pend_value;
    logic [1:0]    pend_mode;
    logic [3:0]    pend_label;
    logic [3:0]    pend_dots;
    logic          pend_blink;
    logic          accept;
    logic          commit;

    // Shadow (currently displayed) request
    logic [15:0]   sh_value;
    logic [1:0]    sh_mode;
    logic [3:0]    sh_label;
    logic [3:0]    sh_dots;
    logic          sh_blink;

    // Shadow contents as they will be after this cycle's edge
    logic [15:0]   nx_value;
    logic [1:0]    nx_mode;
    logic [3:0]    nx_label;
    logic [3:0]    nx_dots;
    logic          nx_blink;

    // Blink state
    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic          blink_wrap;
    logic          phase_nxt;

    // Decoded output values, loaded into the output registers at a frame boundary
    logic [3:0]    dec_dig1;
    logic [3:0]    dec_dig2;
    logic [3:0]    dec_dig3;
    logic [3:0]    dec_dig4;
    logic [3:0]    dec_dots;
    logic [3:0]    dec_auxs;

    assign tick      = (pre == PRE_LAST);
    assign frame_end = tick && (dig == 2'd3);

    // Accept and commit are mutually exclusive: one needs the slot empty, the other full.
    assign loadReady = ~pend_full;
    assign accept    = loadValid && ~pend_full;
    assign commit    = frame_end && pend_full;

    assign blink_wrap = frame_end && (frame_cnt == FRAME_LAST);
    assign phase_nxt  = blink_wrap ? ~phase : phase;

    // Prescaler: advance the scanned digit once every PRESCALE cycles.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            pre <= '0;
            dig <= 2'd0;
        end else if (tick) begin
            pre <= '0;
            dig <= dig + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Pending slot: capture on handshake, release when the frame boundary commits it.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            pend_full  <= 1'b0;
            pend_value <= '0;
            pend_mode  <= MODE_BLANK;
            pend_label <= '0;
            pend_dots  <= '0;
            pend_blink <= 1'b0;
        end else if (accept) begin
            pend_full  <= 1'b1;
            pend_value <= loadValue;
            pend_mode  <= loadMode;
            pend_label <= loadLabel;
            pend_dots  <= loadDots;
            pend_blink <= loadBlink;
        end else if (commit) begin
            pend_full  <= 1'b0;
        end
    end

    // Shadow registers: take the pending request only at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            sh_value <= '0;
            sh_mode  <= MODE_BLANK;
            sh_label <= '0;
            sh_dots  <= '0;
            sh_blink <= 1'b0;
        end else if (commit) begin
            sh_value <= pend_value;
            sh_mode  <= pend_mode;
            sh_label <= pend_label;
            sh_dots  <= pend_dots;
            sh_blink <= pend_blink;
        end
    end

    // Blink: free-running frame counter, phase flips every BLINK_DIV frames; commits do not touch it.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Look ahead to the post-edge shadow so a commit shows in the same cycle dig returns to 0.
    always_comb begin
        nx_value = sh_value;
        nx_mode  = sh_mode;
        nx_label = sh_label;
        nx_dots  = sh_dots;
        nx_blink = sh_blink;
        if (commit) begin
            nx_value = pend_value;
            nx_mode  = pend_mode;
            nx_label = pend_label;
            nx_dots  = pend_dots;
            nx_blink = pend_blink;
        end
    end

    // Decode the post-edge shadow into digit codes, aux selects and gated dots.
    always_comb begin
        dec_dig1 = 4'd0;
        dec_dig2 = 4'd0;
        dec_dig3 = 4'd0;
        dec_dig4 = 4'd0;
        dec_auxs = 4'b1111;
        dec_dots = 4'b0000;
        case (nx_mode)
            MODE_HEX: begin
                dec_dig1 = nx_value[15:12];
                dec_dig2 = nx_value[11:8];
                dec_dig3 = nx_value[7:4];
                dec_dig4 = nx_value[3:0];
                dec_auxs = 4'b0000;
                dec_dots = (!nx_blink || phase_nxt) ? nx_dots : 4'b0000;
            end
            MODE_LABEL: begin
                // The label replaces the top nibble; unknown label codes pass through and render blank.
                dec_dig1 = nx_label;
                dec_dig2 = nx_value[11:8];
                dec_dig3 = nx_value[7:4];
                dec_dig4 = nx_value[3:0];
                dec_auxs = 4'b0001;
                dec_dots = (!nx_blink || phase_nxt) ? nx_dots : 4'b0000;
            end
            default: begin
                // Blank: aux code 0 on every digit, dots off.
                dec_dig1 = 4'd0;
                dec_dig2 = 4'd0;
                dec_dig3 = 4'd0;
                dec_dig4 = 4'd0;
                dec_auxs = 4'b1111;
                dec_dots = 4'b0000;
            end
        endcase
    end

    // Output registers: commits and blink toggles both land on a frame boundary, so update only there.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            dig1 <= 4'd0;
            dig2 <= 4'd0;
            dig3 <= 4'd0;
            dig4 <= 4'd0;
            dots <= 4'b0000;
            auxs <= 4'b1111;
        end else if (frame_end) begin
            dig1 <= dec_dig1;
            dig2 <= dec_dig2;
            dig3 <= dec_dig3;
            dig4 <= dec_dig4;
            dots <= dec_dots;
            auxs <= dec_auxs;
        end
    end

endmodule
